// File: rtl/cp0_multi_int_if.sv
// Pipeline <-> CP0 bundle: mfc0/mtc0 access, exception/ERET events, interrupt lines, redirect and interrupt request.
interface cp0_multi_int_if #(
    parameter int NR_HW_INT = 6
);
    logic [4:0]           reg_read_addr;
    logic [31:0]          reg_read_data;
    logic                 reg_write_en;
    logic [4:0]           reg_write_addr;
    logic [31:0]          reg_write_data;
    logic                 exc_valid;
    logic [4:0]           exc_code;
    logic [31:0]          exc_epc;
    logic [31:0]          exc_badvaddr;
    logic                 eret;
    logic [NR_HW_INT-1:0] hw_int;
    logic                 int_req;
    logic                 exc_jmp_flag;
    logic [31:0]          exc_jmp_dest;

    modport master (
        output reg_read_addr, reg_write_en, reg_write_addr, reg_write_data,
               exc_valid, exc_code, exc_epc, exc_badvaddr, eret, hw_int,
        input  reg_read_data, int_req, exc_jmp_flag, exc_jmp_dest
    );

    modport slave (
        input  reg_read_addr, reg_write_en, reg_write_addr, reg_write_data,
               exc_valid, exc_code, exc_epc, exc_badvaddr, eret, hw_int,
        output reg_read_data, int_req, exc_jmp_flag, exc_jmp_dest
    );
endinterface

// File: rtl/cp0_multi_int.sv
// CP0 state, Count/Compare timer, interrupt masking and exception/ERET redirect; CP0_VECTORED_INT_EN adds vectored interrupts.
// Reads are combinational, int_req and redirect are registered (1 cycle); no backpressure, every event is taken when presented.
module cp0_multi_int #(
    parameter int          NR_HW_INT   = 6,
    parameter int          COUNT_DIV   = 1,
    parameter logic [31:0] VEC_SPACING = 32'h20
) (
    input  logic           clk,
    input  logic           rst,
    cp0_multi_int_if.slave bus
);
`ifdef CP0_VECTORED_INT_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif
    localparam int            PW         = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [31:0]   r_badvaddr, r_count, r_entryhi, r_compare, r_status, r_epc;
    logic [29:0]   r_ebase;
    logic [1:0]    r_ip_sw;
    logic [4:0]    r_exccode;
    logic          r_iv;
    logic [PW-1:0] r_presc;
    logic          r_timer_pending;
    logic          r_int_req;
    logic          r_jmp_flag;
    logic [31:0]   r_jmp_dest;

    logic          w_hw5;
    logic [7:0]    w_ip;
    logic [7:0]    w_pend;
    logic [2:0]    w_vec_n;
    logic [31:0]   w_base;
    logic [31:0]   w_exc_off;
    logic [31:0]   w_cause;
    logic          w_wr;
    logic          w_cnt_wr;
    logic          w_cmp_wr;
    logic          w_presc_tc;
    logic          w_tlb_code;
    logic          w_ehi_code;

    // The sixth line shares IP7 with the timer.
    if (NR_HW_INT > 5) begin : g_hw5
        assign w_hw5 = bus.hw_int[5];
    end else begin : g_no_hw5
        assign w_hw5 = 1'b0;
    end

    always_comb begin
        w_ip = {r_timer_pending | w_hw5, 5'b0, r_ip_sw};
        for (int i = 0; i < 5; i++) begin
            if (i < NR_HW_INT) w_ip[2+i] = bus.hw_int[i];
        end
    end

    assign w_pend     = w_ip & r_status[15:8];
    assign w_cause    = {8'h00, r_iv, 7'h00, w_ip, 1'b0, r_exccode, 2'b00};
    assign w_base     = {2'b10, r_ebase[29:12], 12'h000};
    assign w_wr       = bus.reg_write_en & ~bus.exc_valid & ~bus.eret;
    assign w_cnt_wr   = w_wr && (bus.reg_write_addr == 5'd9);
    assign w_cmp_wr   = w_wr && (bus.reg_write_addr == 5'd11);
    assign w_presc_tc = (r_presc == PRESC_LAST);
    assign w_tlb_code = (bus.exc_code == 5'd2) || (bus.exc_code == 5'd3);
    assign w_ehi_code = w_tlb_code || (bus.exc_code == 5'd1);

    always_comb begin
        w_vec_n = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_pend[i]) w_vec_n = 3'(i);
        end
    end

    always_comb begin
        if (w_tlb_code)                                   w_exc_off = 32'h0000_0000;
        else if (VEC_EN && bus.exc_code == 5'd0 && r_iv)  w_exc_off = 32'h200 + 32'(w_vec_n) * VEC_SPACING;
        else                                              w_exc_off = 32'h0000_0180;
    end

    always_comb begin
        case (bus.reg_read_addr)
            5'd8:    bus.reg_read_data = r_badvaddr;
            5'd9:    bus.reg_read_data = r_count;
            5'd10:   bus.reg_read_data = r_entryhi;
            5'd11:   bus.reg_read_data = r_compare;
            5'd12:   bus.reg_read_data = r_status;
            5'd13:   bus.reg_read_data = w_cause;
            5'd14:   bus.reg_read_data = r_epc;
            5'd15:   bus.reg_read_data = {2'b10, r_ebase};
            default: bus.reg_read_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_badvaddr      <= '0;
            r_count         <= '0;
            r_entryhi       <= '0;
            r_compare       <= '0;
            r_status        <= '0;
            r_epc           <= '0;
            r_ebase         <= '0;
            r_ip_sw         <= '0;
            r_exccode       <= '0;
            r_iv            <= 1'b0;
            r_presc         <= '0;
            r_timer_pending <= 1'b0;
            r_int_req       <= 1'b0;
            r_jmp_flag      <= 1'b0;
            r_jmp_dest      <= '0;
        end else begin
            r_int_req  <= (|w_pend) & r_status[0] & ~r_status[1] & ~bus.exc_valid;
            r_jmp_flag <= bus.exc_valid | bus.eret;

            if (w_cnt_wr) begin
                r_count <= bus.reg_write_data;
                r_presc <= '0;
            end else if (w_presc_tc) begin
                r_count <= r_count + 32'd1;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // A Compare write acknowledges the timer even if a match lands this cycle.
            if (w_cmp_wr)
                r_timer_pending <= 1'b0;
            else if (!w_cnt_wr && w_presc_tc && r_count == r_compare)
                r_timer_pending <= 1'b1;

            if (bus.exc_valid) begin
                if (r_status[1]) begin
                    r_jmp_dest <= w_base + 32'h180;
                end else begin
                    r_epc       <= bus.exc_epc;
                    r_badvaddr  <= bus.exc_badvaddr;
                    r_exccode   <= bus.exc_code;
                    r_status[1] <= 1'b1;
                    if (w_ehi_code) r_entryhi[31:13] <= bus.exc_badvaddr[31:13];
                    r_jmp_dest  <= w_base + w_exc_off;
                end
            end else if (bus.eret) begin
                r_status[1] <= 1'b0;
                r_jmp_dest  <= r_epc;
            end else if (w_wr) begin
                case (bus.reg_write_addr)
                    5'd8:  r_badvaddr <= bus.reg_write_data;
                    5'd10: r_entryhi  <= bus.reg_write_data;
                    5'd11: r_compare  <= bus.reg_write_data;
                    5'd12: r_status   <= bus.reg_write_data;
                    5'd13: begin
                        r_ip_sw <= bus.reg_write_data[9:8];
                        r_iv    <= VEC_EN & bus.reg_write_data[23];
                    end
                    5'd14: r_epc      <= bus.reg_write_data;
                    5'd15: r_ebase    <= bus.reg_write_data[29:0];
                    default: ;
                endcase
            end
        end
    end

    assign bus.int_req      = r_int_req;
    assign bus.exc_jmp_flag = r_jmp_flag;
    assign bus.exc_jmp_dest = r_jmp_dest;
endmodule

// File: tb/tb_cp0_multi_int.sv
// Directed plus randomized bench for cp0_multi_int against a register-array reference model.
module tb_cp0_multi_int;
`ifdef CP0_VECTORED_INT_EN
    localparam bit VEC = 1'b1;
`else
    localparam bit VEC = 1'b0;
`endif
    localparam int COUNT_DIV = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    cp0_multi_int_if #(.NR_HW_INT(6)) bus ();
    cp0_multi_int dut (.clk(clk), .rst(rst), .bus(bus));

    always #10 clk = ~clk;

    // Reference state: architectural registers indexed by CP0 number; Cause fields kept apart.
    logic [31:0] m_reg [32];
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    logic        m_iv;
    int          m_presc;
    logic        m_tp, m_int, m_flag;
    logic [31:0] m_dest;

    function automatic logic [7:0] m_ip();
        logic [5:0] hw;
        hw = bus.hw_int;
        return {m_tp | hw[5], hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] v;
        case (a)
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd14: return m_reg[a];
            5'd13: return {8'h0, m_iv, 7'h0, m_ip(), 1'b0, m_code, 2'b0};
            5'd15: begin v = m_reg[15]; return {2'b10, v[29:0]}; end
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from the inputs now applied, then compare registered outputs.
    task automatic tick();
        logic [7:0]  ip, pend;
        logic [31:0] st, base, off, wd;
        logic [4:0]  wa, code;
        logic        wr, incr;
        int          hi;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = 32'h0;
            m_ipsw = 0; m_code = 0; m_iv = 0; m_presc = 0;
            m_tp = 0; m_int = 0; m_flag = 0; m_dest = 0;
        end else begin
            ip   = m_ip();
            st   = m_reg[12];
            pend = ip & st[15:8];
            wa   = bus.reg_write_addr;
            wd   = bus.reg_write_data;
            code = bus.exc_code;
            wr   = bus.reg_write_en && !bus.exc_valid && !bus.eret;
            m_int  = (pend != 0) && st[0] && !st[1] && !bus.exc_valid;
            m_flag = bus.exc_valid || bus.eret;
            incr = 0;
            if (wr && wa == 9) begin
                m_reg[9] = wd; m_presc = 0;
            end else if (m_presc == COUNT_DIV - 1) begin
                incr = 1; m_presc = 0;
            end else begin
                m_presc++;
            end
            if (wr && wa == 11) m_tp = 0;
            else if (incr && m_reg[9] == m_reg[11]) m_tp = 1;
            if (incr) m_reg[9] = m_reg[9] + 1;
            base = 32'h8000_0000 + (m_reg[15] & 32'h3FFF_F000);
            if (bus.exc_valid) begin
                if (st[1]) m_dest = base + 32'h180;
                else begin
                    m_reg[14] = bus.exc_epc;
                    m_reg[8]  = bus.exc_badvaddr;
                    m_code    = code;
                    m_reg[12][1] = 1'b1;
                    if (code inside {5'd1, 5'd2, 5'd3})
                        m_reg[10] = {bus.exc_badvaddr[31:13], m_reg[10][12:0]};
                    if (code == 2 || code == 3) off = 0;
                    else if (VEC && code == 0 && m_iv) begin
                        hi = 0;
                        for (int b = 7; b >= 0; b--) if (pend[b]) begin hi = b; break; end
                        off = 32'h200 + hi * 32'h20;
                    end else off = 32'h180;
                    m_dest = base + off;
                end
            end else if (bus.eret) begin
                m_reg[12][1] = 1'b0;
                m_dest = m_reg[14];
            end else if (wr) begin
                case (wa)
                    5'd8, 5'd10, 5'd11, 5'd12, 5'd14, 5'd15: m_reg[wa] = wd;
                    5'd13: begin m_ipsw = wd[9:8]; if (VEC) m_iv = wd[23]; end
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        chk("int_req", {31'h0, bus.int_req}, {31'h0, m_int});
        chk("jmp_flag", {31'h0, bus.exc_jmp_flag}, {31'h0, m_flag});
        chk("jmp_dest", bus.exc_jmp_dest, m_dest);
        bus.reg_write_en = 0;
        bus.exc_valid    = 0;
        bus.eret         = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.reg_read_addr = a;
        #1;
        d = bus.reg_read_data;
    endtask

    task automatic rd_chk(input logic [4:0] a);
        logic [31:0] d;
        rd(a, d);
        chk($sformatf("read_r%0d", a), d, m_read(a));
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
        bus.reg_write_en = 1; bus.reg_write_addr = a; bus.reg_write_data = d;
        tick();
    endtask

    task automatic take_exc(input logic [4:0] code, input logic [31:0] epc, input logic [31:0] bad);
        bus.exc_valid = 1; bus.exc_code = code; bus.exc_epc = epc; bus.exc_badvaddr = bad;
        tick();
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  a;
        bus.reg_read_addr = 0; bus.reg_write_en = 0; bus.reg_write_addr = 0; bus.reg_write_data = 0;
        bus.exc_valid = 0; bus.exc_code = 0; bus.exc_epc = 0; bus.exc_badvaddr = 0;
        bus.eret = 0; bus.hw_int = 0;

        // Reset state
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 32; i++) begin
            if (i % 8 == 0 && i > 0) tick();
            rd_chk(5'(i));
        end
        rd(5'd15, d); chk("ebase_reset", d, 32'h8000_0000);
        for (int i = 0; i < 5; i++) tick();
        rd_chk(5'd9);

        // Timer match raises IP7, Compare write clears it
        wr_reg(9, 0); wr_reg(11, 10); wr_reg(12, 32'h0000_8001);
        for (int i = 0; i < 40 && !bus.int_req; i++) tick();
        chk("timer_irq", {31'h0, bus.int_req}, 32'h1);
        wr_reg(11, 20); tick();
        chk("timer_clr", {31'h0, bus.int_req}, 32'h0);

        // Hardware line 0 through IM2, then masked by EXL
        bus.hw_int = 6'b000001;
        wr_reg(12, 32'h0000_0401); tick();
        chk("hw_irq", {31'h0, bus.int_req}, 32'h1);
        take_exc(0, 32'h8000_0100, 32'h0);
        chk("exc_int_dest", bus.exc_jmp_dest, 32'h8000_0180);
        tick();
        chk("exl_mask", {31'h0, bus.int_req}, 32'h0);
        bus.eret = 1; tick();
        chk("eret_dest1", bus.exc_jmp_dest, 32'h8000_0100);
        bus.hw_int = 0;

        // TLB exception, then nested exception while EXL
        wr_reg(15, 32'h8000_1000);
        take_exc(2, 32'h8000_0200, 32'h8000_3004);
        chk("tlb_flag", {31'h0, bus.exc_jmp_flag}, 32'h1);
        chk("tlb_dest", bus.exc_jmp_dest, 32'h8000_1000);
        tick();
        chk("flag_pulse", {31'h0, bus.exc_jmp_flag}, 32'h0);
        rd(5'd10, d); chk("entryhi_vpn", {13'h0, d[31:13]}, 32'h0004_0001);
        rd(5'd13, d); chk("cause_code", {27'h0, d[6:2]}, 32'h2);
        take_exc(1, 32'h1234_5678, 32'h0);
        chk("nested_dest", bus.exc_jmp_dest, 32'h8000_1180);
        rd(5'd14, d); chk("epc_kept", d, 32'h8000_0200);
        rd(5'd8, d);  chk("badv_kept", d, 32'h8000_3004);

        // ERET beats a simultaneous Status write
        wr_reg(14, 32'h8000_0040);
        bus.eret = 1; bus.reg_write_en = 1; bus.reg_write_addr = 12; bus.reg_write_data = 32'hFFFF_FFFF;
        tick();
        chk("eret_dest2", bus.exc_jmp_dest, 32'h8000_0040);
        rd(5'd12, d); chk("eret_status", d, 32'h0000_0401);

        // Interrupt vector selection from IP3
        wr_reg(15, 32'h8000_0000); wr_reg(13, 32'h0080_0000); wr_reg(12, 32'h0000_0800);
        bus.hw_int = 6'b000010;
        take_exc(0, 32'h8000_0300, 32'h0);
`ifdef CP0_VECTORED_INT_EN
        chk("vec_dest", bus.exc_jmp_dest, 32'h8000_0260);
`else
        chk("vec_dest", bus.exc_jmp_dest, 32'h8000_0180);
`endif
        bus.eret = 1; tick();
        rd_chk(5'd13);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 4) == 0) bus.hw_int = 6'($urandom);
            if ($urandom_range(0, 99) < 35) begin
                a = ($urandom_range(0, 9) < 8) ? 5'(8 + $urandom_range(0, 7)) : 5'($urandom_range(0, 31));
                bus.reg_write_en   = 1;
                bus.reg_write_addr = a;
                bus.reg_write_data = (a == 11) ? m_reg[9] + $urandom_range(0, 6) : $urandom;
            end
            if ($urandom_range(0, 99) < 6) begin
                bus.exc_valid = 1; bus.exc_code = 5'($urandom_range(0, 3));
                bus.exc_epc = $urandom; bus.exc_badvaddr = $urandom;
            end
            if ($urandom_range(0, 99) < 6) bus.eret = 1;
            tick();
            rd_chk(5'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
